// File: rtl/inst_fifo.sv
// inst_fifo: dual-read instruction queue between fetch and dual-issue decode.
// Ports: clk, rst (async high), flush; write side w_fifo/w_pc/w_inst/
//   w_pred_target/w_flags; read side r_ena0/r_ena1 and r0_*/r1_* (two oldest
//   entries, combinational); fifo_stall (registered back-pressure), fifo_ovf
//   (sticky overflow). Define INST_FIFO_PERF_EN to add perf_stall_cycles and
//   perf_empty_cycles counters.
module inst_fifo #(
    parameter int DEPTH    = 16,
    parameter int PTR_W    = 4,
    parameter int STALL_TH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        w_fifo,
    input  logic [31:0] w_pc,
    input  logic [31:0] w_inst,
    input  logic [31:0] w_pred_target,
    input  logic [3:0]  w_flags,
    input  logic        r_ena0,
    input  logic        r_ena1,
    output logic        r0_valid,
    output logic [31:0] r0_pc,
    output logic [31:0] r0_inst,
    output logic [31:0] r0_pred_target,
    output logic [3:0]  r0_flags,
    output logic        r1_valid,
    output logic [31:0] r1_pc,
    output logic [31:0] r1_inst,
    output logic [31:0] r1_pred_target,
    output logic [3:0]  r1_flags,
    output logic        fifo_stall,
`ifdef INST_FIFO_PERF_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_empty_cycles,
`endif
    output logic        fifo_ovf
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pred_target;
        logic [3:0]  flags;
    } entry_t;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] TH   = (PTR_W+1)'(STALL_TH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head1;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   next_count;
    logic [PTR_W:0]   next_free;
    logic             full;
    logic             push;
    logic             pop0;
    logic             pop1;
    logic [1:0]       pops;

    // Pointers are exactly PTR_W bits, so +1 wraps mod DEPTH for free.
    assign head1 = head + 1'b1;

    assign r0_pc          = mem[head].pc;
    assign r0_inst        = mem[head].inst;
    assign r0_pred_target = mem[head].pred_target;
    assign r0_flags       = mem[head].flags;
    assign r1_pc          = mem[head1].pc;
    assign r1_inst        = mem[head1].inst;
    assign r1_pred_target = mem[head1].pred_target;
    assign r1_flags       = mem[head1].flags;

    assign r0_valid = (count != '0);
    assign r1_valid = (count > (PTR_W+1)'(1));

    // Fullness is judged before this cycle's pops: a push at full is dropped.
    assign full = (count == FULL);
    assign push = w_fifo & ~full & ~flush;
    assign pop0 = r_ena0 & r0_valid;
    assign pop1 = r_ena0 & r_ena1 & r1_valid;
    assign pops = {1'b0, pop0} + {1'b0, pop1};

    always_comb begin
        next_count = '0;
        if (!flush)
            next_count = count + (PTR_W+1)'(push) - (PTR_W+1)'(pops);
    end

    assign next_free = FULL - next_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            fifo_stall <= 1'b0;
            fifo_ovf   <= 1'b0;
        end else begin
            count      <= next_count;
            fifo_stall <= (next_free <= TH);
            if (flush) begin
                head     <= '0;
                tail     <= '0;
                fifo_ovf <= 1'b0;
            end else begin
                head <= head + PTR_W'(pops);
                if (push)
                    tail <= tail + 1'b1;
                if (w_fifo && full)
                    fifo_ovf <= 1'b1;
            end
        end
    end

    // Flush only rewinds pointers; stale storage is left in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[tail] <= '{pc: w_pc, inst: w_inst,
                           pred_target: w_pred_target,
                           flags: w_flags};
        end
    end

`ifdef INST_FIFO_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_empty_cycles <= '0;
        end else begin
            if (fifo_stall)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (count == '0)
                perf_empty_cycles <= perf_empty_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fifo.sv
// tb_inst_fifo: directed + random checks of inst_fifo against a queue model.
// Ports: none (self-contained bench).
module tb_inst_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        w_fifo;
    logic [31:0] w_pc;
    logic [31:0] w_inst;
    logic [31:0] w_pred_target;
    logic [3:0]  w_flags;
    logic        r_ena0;
    logic        r_ena1;
    logic        r0_valid;
    logic [31:0] r0_pc;
    logic [31:0] r0_inst;
    logic [31:0] r0_pred_target;
    logic [3:0]  r0_flags;
    logic        r1_valid;
    logic [31:0] r1_pc;
    logic [31:0] r1_inst;
    logic [31:0] r1_pred_target;
    logic [3:0]  r1_flags;
    logic        fifo_stall;
    logic        fifo_ovf;
`ifdef INST_FIFO_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_empty_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [99:0] q[$];
    logic        m_ovf;
    logic        m_stall;

    always #5 clk = ~clk;

    inst_fifo dut (
        .clk(clk), .rst(rst), .flush(flush),
        .w_fifo(w_fifo), .w_pc(w_pc), .w_inst(w_inst),
        .w_pred_target(w_pred_target), .w_flags(w_flags),
        .r_ena0(r_ena0), .r_ena1(r_ena1),
        .r0_valid(r0_valid), .r0_pc(r0_pc), .r0_inst(r0_inst),
        .r0_pred_target(r0_pred_target), .r0_flags(r0_flags),
        .r1_valid(r1_valid), .r1_pc(r1_pc), .r1_inst(r1_inst),
        .r1_pred_target(r1_pred_target), .r1_flags(r1_flags),
        .fifo_stall(fifo_stall),
`ifdef INST_FIFO_PERF_EN
        .perf_stall_cycles(perf_stall_cycles),
        .perf_empty_cycles(perf_empty_cycles),
`endif
        .fifo_ovf(fifo_ovf)
    );

    task automatic chk(input string tag, input logic [99:0] obs,
                       input logic [99:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("r0_valid", 100'(r0_valid), 100'(q.size() >= 1));
        chk("r1_valid", 100'(r1_valid), 100'(q.size() >= 2));
        chk("stall", 100'(fifo_stall), 100'(m_stall));
        chk("ovf", 100'(fifo_ovf), 100'(m_ovf));
        if (q.size() >= 1)
            chk("r0_data", {r0_pc, r0_inst, r0_pred_target, r0_flags}, q[0]);
        if (q.size() >= 2)
            chk("r1_data", {r1_pc, r1_inst, r1_pred_target, r1_flags}, q[1]);
    endtask

    // One clock: model consumes the inputs seen at the edge, then compare.
    task automatic step();
        int  np;
        bit  was_full;
        logic [99:0] wr;
        @(posedge clk);
        wr = {w_pc, w_inst, w_pred_target, w_flags};
        if (flush) begin
            q.delete();
            m_ovf   = 1'b0;
            m_stall = 1'b0;
        end else begin
            np = 0;
            was_full = (q.size() == 16);
            if (r_ena0 && q.size() >= 1) np++;
            if (r_ena0 && r_ena1 && q.size() >= 2) np++;
            if (w_fifo && was_full) m_ovf = 1'b1;
            repeat (np) void'(q.pop_front());
            if (w_fifo && !was_full) q.push_back(wr);
            m_stall = (16 - q.size()) <= 2;
        end
        #1;
        check_all();
    endtask

    task automatic set_wr(input logic [31:0] pc);
        w_fifo        = 1'b1;
        w_pc          = pc;
        w_inst        = $urandom;
        w_pred_target = $urandom;
        w_flags       = 4'($urandom);
    endtask

    task automatic idle();
        w_fifo = 1'b0;
        r_ena0 = 1'b0;
        r_ena1 = 1'b0;
        flush  = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        rst = 1'b1;
        idle();
        w_pc = '0; w_inst = '0; w_pred_target = '0; w_flags = '0;
        m_ovf = 1'b0; m_stall = 1'b0;
        #1;
        chk("rst_r0_valid", 100'(r0_valid), 100'(0));
        chk("rst_r1_valid", 100'(r1_valid), 100'(0));
        chk("rst_stall", 100'(fifo_stall), 100'(0));
        chk("rst_ovf", 100'(fifo_ovf), 100'(0));
        chk("rst_r0_pc", 100'(r0_pc), 100'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Order
        for (int i = 0; i < 3; i++) begin
            set_wr(32'hbfc00000 + 32'(4 * i));
            step();
        end
        idle();
        chk("ord_r0_pc", 100'(r0_pc), 100'(32'hbfc00000));
        chk("ord_r1_pc", 100'(r1_pc), 100'(32'hbfc00004));
        r_ena0 = 1'b1; r_ena1 = 1'b1;
        step();
        chk("ord_pop2_pc", 100'(r0_pc), 100'(32'hbfc00008));
        chk("ord_pop2_r1v", 100'(r1_valid), 100'(0));

        // Reset mid-traffic
        idle();
        for (int i = 0; i < 5; i++) begin
            set_wr($urandom);
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        q.delete(); m_ovf = 1'b0; m_stall = 1'b0;
        chk("mid_rst_r0v", 100'(r0_valid), 100'(0));
        chk("mid_rst_r1v", 100'(r1_valid), 100'(0));
        chk("mid_rst_stall", 100'(fifo_stall), 100'(0));
        chk("mid_rst_pc", 100'(r0_pc), 100'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        idle();

        // Full / stall / overflow
        pc = 32'h1000;
        for (int i = 0; i < 14; i++) begin
            set_wr(pc); pc += 4;
            step();
        end
        chk("stall_at14", 100'(fifo_stall), 100'(1));
        for (int i = 0; i < 3; i++) begin
            set_wr(pc); pc += 4;
            step();
        end
        chk("ovf_at17", 100'(fifo_ovf), 100'(1));

        // Push + pop at full: push dropped
        set_wr(pc); pc += 4;
        r_ena0 = 1'b1;
        step();
        idle();
        chk("full_pushpop_r0", 100'(r0_pc), 100'(32'h1004));
        r_ena0 = 1'b1; r_ena1 = 1'b1;
        repeat (8) step();
        chk("drained", 100'(r0_valid), 100'(0));
        chk("ovf_sticky", 100'(fifo_ovf), 100'(1));
        idle(); flush = 1'b1;
        step();
        idle();

        // Wrap across index 15 -> 0
        pc = 32'h2000;
        for (int i = 0; i < 12; i++) begin
            set_wr(pc); pc += 4;
            step();
        end
        idle(); r_ena0 = 1'b1; r_ena1 = 1'b1;
        repeat (6) step();
        idle();
        for (int i = 0; i < 12; i++) begin
            set_wr(pc); pc += 4;
            step();
        end
        idle();
        chk("wrap_head_pc", 100'(r0_pc), 100'(32'h2030));
        chk("wrap_stall", 100'(fifo_stall), 100'(0));

        // Down to 5, then push + pop 2
        r_ena0 = 1'b1;
        step();
        r_ena1 = 1'b1;
        repeat (3) step();
        set_wr(pc); pc += 4;
        step();
        idle();

        // Refill to 9 then flush with write and pop
        for (int i = 0; i < 5; i++) begin
            set_wr(pc); pc += 4;
            step();
        end
        set_wr(pc); r_ena0 = 1'b1; flush = 1'b1;
        step();
        idle();
        chk("flush_r0v", 100'(r0_valid), 100'(0));
        set_wr(32'hcafe0000);
        step();
        idle();
        chk("post_flush_pc", 100'(r0_pc), 100'(32'hcafe0000));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) set_wr($urandom);
            else w_fifo = 1'b0;
            r_ena0 = ($urandom_range(0, 2) == 0);
            r_ena1 = 1'($urandom);
            flush  = ($urandom_range(0, 39) == 0);
            step();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
